// File: rtl/arf_tap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arf_tap_sequencer_pkg
//  Description : Shared types and constants for the ARF tap sequencer:
//                FSM state encoding, datapath widths, saturation limits and
//                the signed-overflow clamp helper.
//  Revision    : 1.0  initial release
// ============================================================================
package arf_tap_sequencer_pkg;

    localparam int c_data_w  = 32;  // sample / accumulator / operand width
    localparam int c_coef_w  = 16;  // coefficient width
    localparam int c_slice_w = 16;  // sample bits consumed by the multiplier

    localparam logic [c_data_w-1:0] c_sat_max = 32'h7FFF_FFFF;
    localparam logic [c_data_w-1:0] c_sat_min = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Clamp a two's-complement sum: overflow happened when both operands
    // share a sign and the sum carries the other one.
    function automatic logic [c_data_w-1:0] sat_sum(
        input logic [c_data_w-1:0] a,
        input logic [c_data_w-1:0] b,
        input logic [c_data_w-1:0] sum
    );
        if ((a[c_data_w-1] == b[c_data_w-1]) && (sum[c_data_w-1] != a[c_data_w-1]))
            return a[c_data_w-1] ? c_sat_min : c_sat_max;
        else
            return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arf_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : arf_coef_bank
//  Description : TAPS x 16-bit coefficient register file. One synchronous
//                write port (caller gates it to IDLE), one combinational
//                read port indexed by the current tap.
//  Ports       : clk, rst       clock / synchronous active-high reset
//                i_we           write strobe (already state-qualified)
//                i_waddr        write tap index; indices >= TAPS ignored
//                i_wdata        write coefficient
//                i_raddr        read tap index
//                o_rdata        coefficient at i_raddr (0 if out of range)
//  Revision    : 1.0  initial release
// ============================================================================
module arf_coef_bank
    import arf_tap_sequencer_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int CW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [CW-1:0]       i_waddr,
    input  logic [c_coef_w-1:0] i_wdata,
    input  logic [CW-1:0]       i_raddr,
    output logic [c_coef_w-1:0] o_rdata
);

    logic [c_coef_w-1:0] r_coef [TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
        end else if (i_we && (int'(i_waddr) < TAPS)) begin
            r_coef[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (int'(i_raddr) < TAPS) o_rdata = r_coef[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/arf_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : arf_tap_sequencer
//  Description : Time-multiplexed sequencer for the ARF datapath. Keeps a
//                TAPS-deep sample delay line and a coefficient bank, and
//                computes y = sum(coef[i]*x[i]) by issuing operands to one
//                external multiplier and one external adder (both
//                combinational), two cycles per tap.
//  Config      : ARF_SAT_EN - when defined, the accumulator saturates on
//                signed overflow instead of wrapping.
//  Ports       : clk, rst                 clock / sync active-high reset
//                in_valid/in_ready/in_data  sample handshake (32-bit signed)
//                coef_we/coef_addr/coef_data coefficient write (IDLE only)
//                mul_in_0/mul_in_1/mul_out  multiplier wrapper interface
//                add_in_0/add_in_1/add_out  adder wrapper interface
//                out_valid/out_ready/out_data result handshake
//  Revision    : 1.0  initial release
// ============================================================================
module arf_tap_sequencer
    import arf_tap_sequencer_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int CW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [c_data_w-1:0] in_data,
    input  logic                coef_we,
    input  logic [CW-1:0]       coef_addr,
    input  logic [c_coef_w-1:0] coef_data,
    output logic [c_data_w-1:0] mul_in_0,
    output logic [c_data_w-1:0] mul_in_1,
    input  logic [c_data_w-1:0] mul_out,
    output logic [c_data_w-1:0] add_in_0,
    output logic [c_data_w-1:0] add_in_1,
    input  logic [c_data_w-1:0] add_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [c_data_w-1:0] out_data
);

    localparam logic [CW-1:0] c_last_tap = CW'(TAPS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_data_w-1:0] r_x [TAPS];
    logic [c_data_w-1:0] r_acc;
    logic [c_data_w-1:0] r_prod;
    logic [CW-1:0]       r_tap;
    logic [c_coef_w-1:0] w_coef;
    logic [c_data_w-1:0] w_acc_next;
    logic                w_coef_we;

    // Coefficients may only change while no computation is in flight.
    assign w_coef_we = coef_we && (r_state == ST_IDLE);

    arf_coef_bank #(
        .TAPS (TAPS),
        .CW   (CW)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_coef_we),
        .i_waddr (coef_addr),
        .i_wdata (coef_data),
        .i_raddr (r_tap),
        .o_rdata (w_coef)
    );

`ifdef ARF_SAT_EN
    assign w_acc_next = sat_sum(r_acc, r_prod, add_out);
`else
    assign w_acc_next = add_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
            r_acc  <= '0;
            r_prod <= '0;
            r_tap  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
                        r_acc <= '0;
                        r_tap <= '0;
                    end
                end
                ST_MUL: r_prod <= mul_out;
                ST_ACC: begin
                    r_acc <= w_acc_next;
                    if (r_tap != c_last_tap) r_tap <= r_tap + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state, so out_valid/out_data are
    // glitch-free and hold steady while DONE waits on out_ready.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        mul_in_0     = '0;
        mul_in_1     = '0;
        add_in_0     = '0;
        add_in_1     = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = ST_MUL;
            end
            ST_MUL: begin
                mul_in_0     = r_x[r_tap];
                mul_in_1     = {{(c_data_w-c_coef_w){w_coef[c_coef_w-1]}}, w_coef};
                w_next_state = ST_ACC;
            end
            ST_ACC: begin
                add_in_0     = r_acc;
                add_in_1     = r_prod;
                w_next_state = (r_tap == c_last_tap) ? ST_DONE : ST_MUL;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_arf_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arf_tap_sequencer
//  Description : Directed self-checking bench for arf_tap_sequencer with
//                TAPS=4 and exact multiplier/adder models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arf_tap_sequencer;

    localparam int TAPS = 4;
    localparam int CW   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        coef_we = 1'b0;
    logic [CW-1:0] coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic [31:0] mul_in_0, mul_in_1, mul_out;
    logic [31:0] add_in_0, add_in_1, add_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;
    int shift_width = 8;

    always #5 clk = ~clk;

    // Exact operator models: 16x16 signed product, arithmetic post-shift.
    logic signed [31:0] w_prod_full;
    assign w_prod_full = $signed({{16{mul_in_0[15]}}, mul_in_0[15:0]}) *
                         $signed({{16{mul_in_1[15]}}, mul_in_1[15:0]});
    assign mul_out = w_prod_full >>> shift_width;
    assign add_out = add_in_0 + add_in_1;

    arf_tap_sequencer #(.TAPS(TAPS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mul_in_0  (mul_in_0),
        .mul_in_1  (mul_in_1),
        .mul_out   (mul_out),
        .add_in_0  (add_in_0),
        .add_in_1  (add_in_1),
        .add_out   (add_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [CW-1:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic accept(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge: waits for out_valid, checks
    // latency and value, then consumes the result.
    task automatic await_result(input string tag, input logic [31:0] exp);
        int cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(2*TAPS));
        check(tag, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_mul_in_0", mul_in_0, 32'd0);
        check("rst_mul_in_1", mul_in_1, 32'd0);
        check("rst_add_in_0", add_in_0, 32'd0);
        check("rst_add_in_1", add_in_1, 32'd0);

        // ---------------- impulse / ramp ----------------
        shift_width = 8;
        for (int i = 0; i < TAPS; i++) write_coef(CW'(i), 16'd256);
        accept(32'd1);
        check("mul_op0_tap0", mul_in_0, 32'd1);
        check("mul_op1_tap0", mul_in_1, 32'd256);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        await_result("ramp1", 32'd1);
        accept(32'd2); await_result("ramp2", 32'd3);
        accept(32'd3); await_result("ramp3", 32'd6);
        accept(32'd4); await_result("ramp4", 32'd10);

        // ---------------- backpressure ----------------
        accept(32'd5);
        begin
            int cnt = 0;
            while (!out_valid && cnt < 40) begin step(); cnt++; end
            check("bp_lat", 32'(cnt), 32'(2*TAPS));
        end
        check("bp_result", out_data, 32'd14);
        held = out_data;
        in_valid = 1'b1; in_data = 32'd99;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_data", out_data, held);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_handoff_valid", 32'(out_valid), 32'd0);
        check("bp_handoff_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_accepted", 32'(in_ready), 32'd0);
        await_result("bp_next", 32'd111);

        // ---------------- coefficient routing ----------------
        do_reset();
        shift_width = 0;
        write_coef(2'd0, 16'd4);
        write_coef(2'd1, 16'd3);
        write_coef(2'd2, 16'd2);
        write_coef(2'd3, 16'd1);
        accept(32'd0); await_result("route_a", 32'd0);
        accept(32'd0); await_result("route_b", 32'd0);
        accept(32'd0); await_result("route_c", 32'd0);
        accept(32'd5); await_result("route_d", 32'd20);
        accept(32'd0); await_result("route_e", 32'd15);

        // ---------------- coefficient write gating ----------------
        accept(32'd1);
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd100;
        await_result("gate_cur", 32'd14);
        coef_we = 1'b0;
        accept(32'd2); await_result("gate_next", 32'd16);
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd10;
        in_valid = 1'b1; in_data = 32'd3;
        step();
        coef_we = 1'b0; in_valid = 1'b0;
        await_result("gate_idle_write", 32'd38);

        // ---------------- overflow ----------------
        do_reset();
        shift_width = 0;
        for (int i = 0; i < TAPS; i++) write_coef(CW'(i), 16'h7FFF);
        accept(32'h7FFF); await_result("ovf1", 32'h3FFF_0001);
        accept(32'h7FFF); await_result("ovf2", 32'h7FFE_0002);
`ifdef ARF_SAT_EN
        accept(32'h7FFF); await_result("ovf3", 32'h7FFF_FFFF);
        accept(32'h7FFF); await_result("ovf4", 32'h7FFF_FFFF);
`else
        accept(32'h7FFF); await_result("ovf3", 32'hBFFD_0003);
        accept(32'h7FFF); await_result("ovf4", 32'hFFFC_0004);
`endif

        // ---------------- reset mid-run ----------------
        do_reset();
        shift_width = 8;
        for (int i = 0; i < TAPS; i++) write_coef(CW'(i), 16'd256);
        accept(32'd9); await_result("pre_a", 32'd9);
        accept(32'd3);
        for (int i = 0; i < 5; i++) step();
        check("mid_acc_tap2_prod", add_in_1, 32'd0);
        check("mid_acc_tap2_acc", add_in_0, 32'd12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < TAPS; i++) write_coef(CW'(i), 16'd256);
        accept(32'd7); await_result("mid_rst_result", 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
